// File: rtl/chacha_job_scheduler.sv
// Round-robin scheduler that shares one ChaCha20 engine between NUM_REQ requesters.
// A job runs N blocks, serves the block counter to the engine, and is aborted if a block exceeds TIMEOUT cycles.
module chacha_job_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 4096,
  parameter int TO_W    = 13
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*8-1:0]    req_blocks,
  input  logic [NUM_REQ*32-1:0]   req_counter,
  output logic [NUM_REQ-1:0]      req_accept,
  output logic [NUM_REQ-1:0]      job_done,
  output logic [NUM_REQ-1:0]      job_err,
  output logic                    grant_valid,
  output logic [ID_W-1:0]         grant_id,
  output logic [NUM_REQ-1:0]      owner_onehot,
  output logic [7:0]              blocks_left,
  output logic                    eng_start,
  input  logic                    eng_busy,
  input  logic                    eng_done,
  input  logic                    eng_chunk_request,
  input  logic [1:0]              eng_request_type,
  output logic                    eng_chunk_valid,
  output logic [1:0]              eng_chunk_type,
  output logic [31:0]             eng_chunk
);

  typedef enum logic [1:0] {IDLE, START, RUN, RELEASE} state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [31:0]          counter_q, counter_d;
  logic [7:0]           blocks_q, blocks_d;
  logic [TO_W-1:0]      wdog_q, wdog_d;
  logic                 grant_q, grant_d;
  logic [NUM_REQ-1:0]   owner_q, owner_d;
  logic [NUM_REQ-1:0]   accept_q, accept_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [NUM_REQ-1:0]   err_q, err_d;
  logic                 start_q, start_d;
  logic                 chunk_valid_q, chunk_valid_d;
  logic [31:0]          chunk_q, chunk_d;

  logic [7:0]           blocks_in  [NUM_REQ];
  logic [31:0]          counter_in [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign blocks_in[g]  = req_blocks[8*g +: 8];
    assign counter_in[g] = req_counter[32*g +: 32];
  end

  // Round-robin pick: first pending requester scanning upward from rr_ptr with wrap.
  logic                 arb_found;
  logic [ID_W-1:0]      arb_id;
  logic [NUM_REQ-1:0]   arb_onehot;
  logic [ID_W:0]        arb_sum;

  always_comb begin
    arb_found = 1'b0;
    arb_id    = '0;
    arb_sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      arb_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (arb_sum >= (ID_W+1)'(NUM_REQ)) arb_sum = arb_sum - (ID_W+1)'(NUM_REQ);
      if (!arb_found && req_valid[arb_sum[ID_W-1:0]]) begin
        arb_found = 1'b1;
        arb_id    = arb_sum[ID_W-1:0];
      end
    end
    arb_onehot = NUM_REQ'(1) << arb_id;
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first so no branch can infer a latch.
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    id_d          = id_q;
    counter_d     = counter_q;
    blocks_d      = blocks_q;
    wdog_d        = wdog_q;
    grant_d       = grant_q;
    owner_d       = owner_q;
    accept_d      = '0;
    done_d        = '0;
    err_d         = '0;
    start_d       = 1'b0;
    chunk_valid_d = 1'b0;
    chunk_d       = '0;

    case (state_q)
      IDLE: begin
        if (arb_found) begin
          id_d      = arb_id;
          counter_d = counter_in[arb_id];
          blocks_d  = blocks_in[arb_id];
          accept_d  = arb_onehot;
          grant_d   = 1'b1;
          owner_d   = arb_onehot;
          if (blocks_in[arb_id] == 8'd0) begin
            done_d  = arb_onehot;
            state_d = RELEASE;
          end else begin
            state_d = START;
          end
        end
      end

      START: begin
        // A busy engine may still be finishing an aborted block; never start over it.
        if (!eng_busy) begin
          start_d = 1'b1;
          wdog_d  = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        if (eng_chunk_request && eng_request_type == 2'b10 && !chunk_valid_q) begin
          chunk_valid_d = 1'b1;
          chunk_d       = counter_q;
        end
        // Completion takes priority over a watchdog expiry in the same cycle.
        if (eng_done) begin
          blocks_d  = blocks_q - 8'd1;
          counter_d = counter_q + 32'd1;
          if (blocks_q == 8'd1) begin
            done_d  = owner_q;
            state_d = RELEASE;
          end else begin
            state_d = START;
          end
        end else if (wdog_q == TO_W'(TIMEOUT - 1)) begin
          err_d   = owner_q;
          state_d = RELEASE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end

      RELEASE: begin
        grant_d  = 1'b0;
        owner_d  = '0;
        rr_ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      id_q          <= '0;
      counter_q     <= '0;
      blocks_q      <= '0;
      wdog_q        <= '0;
      grant_q       <= 1'b0;
      owner_q       <= '0;
      accept_q      <= '0;
      done_q        <= '0;
      err_q         <= '0;
      start_q       <= 1'b0;
      chunk_valid_q <= 1'b0;
      chunk_q       <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      id_q          <= id_d;
      counter_q     <= counter_d;
      blocks_q      <= blocks_d;
      wdog_q        <= wdog_d;
      grant_q       <= grant_d;
      owner_q       <= owner_d;
      accept_q      <= accept_d;
      done_q        <= done_d;
      err_q         <= err_d;
      start_q       <= start_d;
      chunk_valid_q <= chunk_valid_d;
      chunk_q       <= chunk_d;
    end
  end

  assign req_accept      = accept_q;
  assign job_done        = done_q;
  assign job_err         = err_q;
  assign grant_valid     = grant_q;
  assign grant_id        = id_q & {ID_W{grant_q}};
  assign owner_onehot    = owner_q;
  assign blocks_left     = blocks_q;
  assign eng_start       = start_q;
  assign eng_chunk_valid = chunk_valid_q;
  assign eng_chunk_type  = {chunk_valid_q, 1'b0};
  assign eng_chunk       = chunk_q;

endmodule

// File: doc/chacha_job_scheduler.md
Name: chacha_job_scheduler

Overview:
Shares one asic_top ChaCha20 engine between NUM_REQ requesters using round-robin arbitration. A granted job is a run of N consecutive 512-bit blocks. The scheduler pulses the engine start once per block and answers the engine's streamed-counter requests with base_counter + block index. It also enforces a per-block watchdog and reports done/error per requester. Key, nonce and plaintext/ciphertext streaming are outside this block; other logic routes them using owner_onehot.

Parameters:
NUM_REQ, 4, number of requester channels (2..8)
ID_W, 2, width of grant_id; must be >= clog2(NUM_REQ)
TIMEOUT, 4096, maximum cycles from eng_start to eng_done before the job is aborted
TO_W, 13, watchdog counter width; must hold TIMEOUT

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester job pending, level-held
req_blocks  in  NUM_REQ*8  per-requester block count; slice i = [8i+7:8i]
req_counter  in  NUM_REQ*32  per-requester base counter; slice i = [32i+31:32i]
req_accept  out  NUM_REQ  one-cycle pulse: job i latched
job_done  out  NUM_REQ  one-cycle pulse: job i completed all blocks
job_err  out  NUM_REQ  one-cycle pulse: job i aborted by watchdog
grant_valid  out  1  a job currently owns the engine
grant_id  out  ID_W  index of owner; valid when grant_valid=1
owner_onehot  out  NUM_REQ  one-hot owner; 0 when idle
blocks_left  out  8  blocks remaining in current job
eng_start  out  1  one-cycle start pulse to engine
eng_busy  in  1  engine busy
eng_done  in  1  engine block complete, one-cycle pulse
eng_chunk_request  in  1  engine chunk request
eng_request_type  in  2  requested chunk type: 0 key, 1 nonce, 2 counter
eng_chunk_valid  out  1  counter chunk valid
eng_chunk_type  out  2  always 2'b10 when eng_chunk_valid=1
eng_chunk  out  32  counter value

Behaviour:
- Reset: every output 0; FSM to IDLE; rr_ptr=0; watchdog=0. Reset mid-job aborts immediately. No done/err pulse is issued for the aborted job.
- States: IDLE, START, RUN, RELEASE.
- IDLE, arbitration: when any req_valid is set, select the first set index scanning rr_ptr, rr_ptr+1, ... with wrap.
- IDLE, latching: in the same cycle, latch id, cur_counter = req_counter slice and blocks_left = req_blocks slice.
- IDLE, outputs: pulse req_accept[id]. Set grant_valid=1 and grant_id/owner_onehot registered, visible the next cycle.
- IDLE, next state: go to START. If req_blocks = 0, go to RELEASE instead, with a job_done[id] pulse and no engine activity.
- START: wait while eng_busy=1. When eng_busy=0, pulse eng_start for exactly 1 cycle, clear the watchdog and go to RUN.
- RUN, counter service: when eng_chunk_request=1, eng_request_type=2'b10 and eng_chunk_valid was 0 in the previous cycle, register next cycle eng_chunk_valid=1, eng_chunk_type=2'b10, eng_chunk=cur_counter.
- RUN, counter service pacing: the response is 1 cycle wide. Back-to-back requests therefore get a response every other cycle at most.
- RUN, other chunk types: requests of type 0 or 1 are ignored (no response).
- RUN, watchdog: increments every RUN cycle.
- RUN, eng_done=1: blocks_left -= 1 and cur_counter += 1 modulo 2^32. 0xFFFFFFFF wraps to 0x00000000 with no error.
- RUN, after eng_done: if the new blocks_left is 0, pulse job_done[id] and go to RELEASE; otherwise go to START.
- RUN, timeout: if the watchdog reaches TIMEOUT without eng_done, pulse job_err[id] and go to RELEASE; blocks_left is left unchanged.
- eng_done and watchdog expiry in the same cycle: done wins and no error is raised.
- eng_done outside RUN is ignored.
- RELEASE: grant_valid=0, owner_onehot=0, rr_ptr = (id+1) mod NUM_REQ, then go to IDLE. This gives a minimum 1-cycle gap between jobs.
- Fairness: a requester holding req_valid is granted within NUM_REQ-1 jobs.
- Requester inputs: req_valid or slice changes after accept have no effect on the running job. A requester must drop req_valid after req_accept or it will be re-granted once its turn returns.
- Engine-abort caveat: after a timeout the engine may still be busy. The next job's START waits on eng_busy, so no start pulse reaches a busy engine.
- Widths: all counter arithmetic is 32-bit unsigned. blocks_left is 8-bit and never underflows.

Test Plan:
- Single job: req_valid[0]=1, blocks=3, counter=0x10. Expect req_accept[0] pulse, 3 eng_start pulses and counter responses 0x10, 0x11, 0x12, then job_done[0] pulse, with grant_valid=0 after RELEASE.
- Round-robin: req_valid=4'b1111 held, each drops on accept, blocks=1. Expect grant order 0,1,2,3. Then with rr_ptr=0 and requests on {1,3}, expect order 1,3.
- Counter wrap: blocks=2, counter=0xFFFFFFFF. Expect responses 0xFFFFFFFF then 0x00000000, then job_done, no err.
- Watchdog: TIMEOUT=16, engine never asserts done. Expect job_err pulse exactly 16 cycles after eng_start, no job_done, and the next job's START held until eng_busy=0.
- Zero-length and collision: blocks=0 gives accept plus job_done with no eng_start. eng_done asserted on the expiry cycle gives done, no err.
- Reset mid-job: assert rst during RUN of block 2/4. Expect all outputs 0 asynchronously and the next job granted from rr_ptr=0.
